// File: rtl/operand2_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : operand2_sequencer
// Description : Computes the ARM data-processing second operand with a serial
//               barrel shifter, one 1-bit shift or rotate per clock, plus the
//               shifter carry-out. The result is presented with a single-cycle
//               done pulse and then held until the next request is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module operand2_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        loadOrStore,
  input  logic        I,
  input  logic [11:0] shiftOperand,
  input  logic [31:0] RmValue,
  input  logic [7:0]  RsValue,
  input  logic        carryIn,
  output logic        busy,
  output logic        done,
  output logic [31:0] secondValue,
  output logic        carryOut
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [2:0] c_LSL = 3'd0;
  localparam logic [2:0] c_LSR = 3'd1;
  localparam logic [2:0] c_ASR = 3'd2;
  localparam logic [2:0] c_ROR = 3'd3;
  localparam logic [2:0] c_RRX = 3'd4;

  logic [1:0]  r_state;
  logic [1:0]  w_nextState;
  logic [5:0]  r_count;
  logic [31:0] r_value;
  logic        r_carry;
  logic [2:0]  r_type;

  logic [31:0] w_loadValue;
  logic        w_loadCarry;
  logic [2:0]  w_loadType;
  logic [5:0]  w_loadCount;
  logic [31:0] w_stepValue;
  logic        w_stepCarry;
  logic        w_accept;

  logic [4:0]  w_immAmount;
  assign w_immAmount = shiftOperand[11:7];
  assign w_accept    = (r_state == c_IDLE) && start;

  // Decode the request into starting value, carry, shift kind and step count
  always_comb begin
    w_loadValue = RmValue;
    w_loadCarry = carryIn;
    w_loadType  = {1'b0, shiftOperand[6:5]};
    w_loadCount = 6'd0;
    if (loadOrStore) begin
      w_loadValue = {20'b0, shiftOperand};
      w_loadType  = c_LSL;
    end else if (I) begin
      w_loadValue = {24'b0, shiftOperand[7:0]};
      w_loadType  = c_ROR;
      w_loadCount = {1'b0, shiftOperand[11:8], 1'b0};
    end else if (!shiftOperand[4]) begin
      // Immediate amount 0 is re-encoded: LSR/ASR #32 and ROR #0 means RRX
      if (w_immAmount == 5'd0) begin
        case (shiftOperand[6:5])
          2'b01, 2'b10: w_loadCount = 6'd32;
          2'b11: begin
            w_loadType  = c_RRX;
            w_loadCount = 6'd1;
          end
          default: w_loadCount = 6'd0;
        endcase
      end else begin
        w_loadCount = {1'b0, w_immAmount};
      end
    end else if (RsValue != 8'd0) begin
      // Beyond 33 (LSL/LSR) or 32 (ASR) steps the result no longer changes
      case (shiftOperand[6:5])
        2'b00, 2'b01: w_loadCount = (RsValue > 8'd33) ? 6'd33 : RsValue[5:0];
        2'b10:        w_loadCount = (RsValue > 8'd32) ? 6'd32 : RsValue[5:0];
        default: begin
          w_loadCount = {1'b0, RsValue[4:0]};
          // Rotate by a nonzero multiple of 32: value unchanged, carry = bit 31
          if (RsValue[4:0] == 5'd0) begin
            w_loadCarry = RmValue[31];
          end
        end
      endcase
    end
  end

  // One single-bit shift step of the current working value
  always_comb begin
    w_stepValue = r_value;
    w_stepCarry = r_carry;
    case (r_type)
      c_LSL: begin
        w_stepCarry = r_value[31];
        w_stepValue = {r_value[30:0], 1'b0};
      end
      c_LSR: begin
        w_stepCarry = r_value[0];
        w_stepValue = {1'b0, r_value[31:1]};
      end
      c_ASR: begin
        w_stepCarry = r_value[0];
        w_stepValue = {r_value[31], r_value[31:1]};
      end
      c_ROR: begin
        w_stepCarry = r_value[0];
        w_stepValue = {r_value[0], r_value[31:1]};
      end
      c_RRX: begin
        w_stepCarry = r_value[0];
        w_stepValue = {r_carry, r_value[31:1]};
      end
      default: begin
        w_stepValue = r_value;
        w_stepCarry = r_carry;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_nextState = (w_loadCount != 6'd0) ? c_SHIFT : c_DONE;
        end
      end
      c_SHIFT: begin
        if (r_count == 6'd1) begin
          w_nextState = c_DONE;
        end
      end
      c_DONE:  w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = (r_state != c_IDLE);
    done = (r_state == c_DONE);
  end

  // Working value, carry and step counter; held outside accept and SHIFT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 6'd0;
      r_value <= 32'd0;
      r_carry <= 1'b0;
      r_type  <= c_LSL;
    end else if (w_accept) begin
      r_count <= w_loadCount;
      r_value <= w_loadValue;
      r_carry <= w_loadCarry;
      r_type  <= w_loadType;
    end else if (r_state == c_SHIFT) begin
      r_count <= r_count - 6'd1;
      r_value <= w_stepValue;
      r_carry <= w_stepCarry;
    end
  end

  assign secondValue = r_value;
  assign carryOut    = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_operand2_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand2_sequencer
// Description : Self-checking bench for operand2_sequencer. A driver issues
//               requests and queues the expected result and done cycle from an
//               arithmetic ARM shifter model; a monitor checks each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand2_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        loadOrStore = 1'b0;
  logic        I = 1'b0;
  logic [11:0] shiftOperand = '0;
  logic [31:0] RmValue = '0;
  logic [7:0]  RsValue = '0;
  logic        carryIn = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] secondValue;
  logic        carryOut;

  operand2_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .loadOrStore(loadOrStore), .I(I),
    .shiftOperand(shiftOperand), .RmValue(RmValue), .RsValue(RsValue),
    .carryIn(carryIn), .busy(busy), .done(done), .secondValue(secondValue),
    .carryOut(carryOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] v;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Shift of rm by n positions with ARM semantics; kind 4 is RRX
  function automatic void shiftRef(input int kind, input int n, input bit [31:0] rm,
                                   input bit cin, output bit [31:0] v, output bit c);
    bit [63:0] d;
    int r;
    v = rm; c = cin;
    if (kind == 4) begin
      v = {cin, rm[31:1]}; c = rm[0];
    end else if (n == 0) begin
      v = rm; c = cin;
    end else if (kind == 0) begin
      if (n < 32) begin v = rm << n; c = rm[32-n]; end
      else if (n == 32) begin v = 0; c = rm[0]; end
      else begin v = 0; c = 0; end
    end else if (kind == 1) begin
      if (n < 32) begin v = rm >> n; c = rm[n-1]; end
      else if (n == 32) begin v = 0; c = rm[31]; end
      else begin v = 0; c = 0; end
    end else if (kind == 2) begin
      if (n < 32) begin v = 32'($signed(rm) >>> n); c = rm[n-1]; end
      else begin v = {32{rm[31]}}; c = rm[31]; end
    end else begin
      r = n % 32;
      if (r == 0) begin v = rm; c = rm[31]; end
      else begin d = {rm, rm}; d = d >> r; v = d[31:0]; c = v[31]; end
    end
  endfunction

  // Operand-2 result and the number of clock steps the serial shifter needs
  function automatic void refModel(input bit ls, input bit ii, input bit [11:0] so,
                                   input bit [31:0] rm, input bit [7:0] rs, input bit cin,
                                   output bit [31:0] v, output bit c, output int lat);
    int kind, amt;
    kind = int'(so[6:5]);
    if (ls) begin
      v = {20'b0, so}; c = cin; lat = 0;
    end else if (ii) begin
      amt = 2 * int'(so[11:8]);
      shiftRef(3, amt, {24'b0, so[7:0]}, cin, v, c);
      lat = amt;
    end else if (!so[4]) begin
      amt = int'(so[11:7]);
      if (amt == 0 && kind == 3) begin
        shiftRef(4, 1, rm, cin, v, c); lat = 1;
      end else if (amt == 0 && kind != 0) begin
        shiftRef(kind, 32, rm, cin, v, c); lat = 32;
      end else begin
        shiftRef(kind, amt, rm, cin, v, c); lat = amt;
      end
    end else begin
      amt = int'(rs);
      shiftRef(kind, amt, rm, cin, v, c);
      if (amt == 0) lat = 0;
      else if (kind <= 1) lat = (amt > 33) ? 33 : amt;
      else if (kind == 2) lat = (amt > 32) ? 32 : amt;
      else lat = amt % 32;
    end
  endfunction

  // Wait (at falling edges) for the sequencer to go idle, optionally poking
  // start with junk while it is busy; those pokes must be ignored
  task automatic waitIdle(input int noisePct);
    int n = 0;
    while (busy) begin
      if ($urandom_range(99) < noisePct) begin
        start = 1'b1; loadOrStore = $urandom_range(1); I = $urandom_range(1);
        shiftOperand = 12'($urandom); RmValue = $urandom; RsValue = 8'($urandom);
        carryIn = $urandom_range(1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL idle_timeout busy=%b after %0d cycles, required 0", busy, n);
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
  endtask

  // Drive one request at a falling edge while idle; queue expected result
  task automatic issueRaw(input bit ls, input bit ii, input bit [11:0] so, input bit [31:0] rm,
                          input bit [7:0] rs, input bit cin, input bit [31:0] ev,
                          input bit ec, input int lat, input bit push);
    exp_t e;
    start = 1'b1; loadOrStore = ls; I = ii; shiftOperand = so;
    RmValue = rm; RsValue = rs; carryIn = cin;
    e.v = ev; e.c = ec; e.cyc = cyc + 1 + lat;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input bit ls, input bit ii, input bit [11:0] so, input bit [31:0] rm,
                       input bit [7:0] rs, input bit cin);
    bit [31:0] v; bit c; int lat;
    refModel(ls, ii, so, rm, rs, cin, v, c, lat);
    issueRaw(ls, ii, so, rm, rs, cin, v, c, lat, 1'b1);
  endtask

  // Scoreboard monitor: every done pulse must match the queue head on time
  bit          prevDone = 1'b0;
  logic [31:0] prevV;
  logic        prevC;
  exp_t        mon;
  always @(negedge clk) begin
    if (rst) begin
      if (prevDone) begin
        checks++;
        if (secondValue !== prevV || carryOut !== prevC) begin
          errors++;
          $display("FAIL hold_after_done got value=%h carry=%b, required value=%h carry=%b",
                   secondValue, carryOut, prevV, prevC);
        end
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_done at cyc=%0d value=%h, required no done", cyc, secondValue);
        end else begin
          mon = sb.pop_front();
          if (secondValue !== mon.v || carryOut !== mon.c || cyc != mon.cyc) begin
            errors++;
            $display("FAIL result got value=%h carry=%b cyc=%0d, required value=%h carry=%b cyc=%0d",
                     secondValue, carryOut, cyc, mon.v, mon.c, mon.cyc);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        checks++; errors++;
        $display("FAIL missing_done at cyc=%0d, required done at cyc=%0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      prevDone = done; prevV = secondValue; prevC = carryOut;
    end else begin
      prevDone = 1'b0;
    end
  end

  task automatic checkZero(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || secondValue !== 32'd0 || carryOut !== 1'b0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b value=%h carry=%b, required all zero",
               name, busy, done, secondValue, carryOut);
    end
  endtask

  initial begin
    bit [11:0] so;
    bit [31:0] rm;
    bit [7:0]  rs;
    #1 rst = 1'b0;
    #2 checkZero("reset_state");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    // First request issued in the very cycle reset is released
    issueRaw(1'b0, 1'b1, 12'h4FF, 32'h0, 8'h0, 1'b0, 32'hFF000000, 1'b1, 8, 1'b1);
    waitIdle(25);
    issueRaw(1'b0, 1'b0, 12'h200, 32'h10000001, 8'h0, 1'b0, 32'h00000010, 1'b1, 4, 1'b1);
    waitIdle(25);
    issueRaw(1'b0, 1'b0, 12'h060, 32'h00000003, 8'h0, 1'b1, 32'h80000001, 1'b1, 1, 1'b1);
    waitIdle(25);
    issueRaw(1'b0, 1'b0, 12'h030, 32'hFFFFFFFF, 8'd40, 1'b1, 32'h0, 1'b0, 33, 1'b1);
    waitIdle(100);
    issueRaw(1'b1, 1'b1, 12'hABC, 32'h12345678, 8'h0, 1'b1, 32'h00000ABC, 1'b1, 0, 1'b1);
    waitIdle(100);
    // Register shift boundary cases
    issue(1'b0, 1'b0, 12'h010, 32'h80000001, 8'd32, 1'b0);
    waitIdle(25);
    issue(1'b0, 1'b0, 12'h030, 32'h80000001, 8'd32, 1'b0);
    waitIdle(25);
    issue(1'b0, 1'b0, 12'h050, 32'h80000000, 8'd99, 1'b0);
    waitIdle(25);
    issue(1'b0, 1'b0, 12'h070, 32'h8000F00F, 8'd64, 1'b0);
    waitIdle(25);
    issue(1'b0, 1'b0, 12'h070, 32'h8000F00F, 8'd0, 1'b1);
    waitIdle(25);

    // Reset in the middle of a 20-step LSL
    issueRaw(1'b0, 1'b0, 12'hA00, 32'hDEADBEEF, 8'h0, 1'b1, 32'h0, 1'b0, 20, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1 checkZero("reset_mid_shift");
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    issue(1'b0, 1'b0, 12'hA00, 32'hDEADBEEF, 8'h0, 1'b1);
    waitIdle(25);

    // Randomized traffic, issued back-to-back at the minimum interval
    for (int k = 0; k < 80; k++) begin
      so = 12'($urandom);
      case ($urandom_range(3))
        0: rm = 32'h80000000;
        1: rm = 32'hFFFFFFFF;
        default: rm = $urandom;
      endcase
      case ($urandom_range(7))
        0: rs = 8'd0;
        1: rs = 8'd32;
        2: rs = 8'd33;
        3: rs = 8'd40;
        4: rs = 8'd31;
        5: rs = 8'd64;
        default: rs = 8'($urandom);
      endcase
      issue(($urandom_range(7) == 0), 1'($urandom_range(1)), so, rm, rs, 1'($urandom_range(1)));
      waitIdle(25);
    end

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand2_sequencer.md
OPERAND2_SEQUENCER -- requirements
Module: operand2_sequencer

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-002 SHALL have ports: start input 1 (request, sampled only when busy=0); loadOrStore input 1; I input 1; shiftOperand input 12; RmValue input 32; RsValue input 8 (Rs[7:0]); carryIn input 1 (CPSR C).
REQ-003 SHALL have ports: busy output 1; done output 1 (one-cycle pulse); secondValue output 32; carryOut output 1 (shifter carry).

Function
REQ-004 SHALL be an FSM with states IDLE, SHIFT, DONE; busy=1 in SHIFT and DONE.
REQ-005 SHALL accept start only in IDLE; start in SHIFT or DONE is ignored, and inputs are not re-sampled.
REQ-006 SHALL latch on the accept edge a working value V, carry C=carryIn, shift type T, and step count N.
REQ-007 loadOrStore=1 (priority over I): V={20'b0,shiftOperand}, N=0.
REQ-008 Otherwise I=1: V={24'b0,shiftOperand[7:0]}, T=ROR, N=2*shiftOperand[11:8] (0..30).
REQ-009 Otherwise shiftOperand[4]=0: V=RmValue, T=shiftOperand[6:5], amt=shiftOperand[11:7]; amt=0 gives LSL N=0, LSR N=32, ASR N=32, and ROR becomes RRX with N=1.
REQ-010 Otherwise (register shift): V=RmValue, T=shiftOperand[6:5], amt=RsValue.
- amt=0: N=0.
- LSL/LSR: N=min(amt,33).
- ASR: N=min(amt,32).
- ROR: N=amt[4:0]; if amt!=0 and amt[4:0]=0, then N=0 and C=RmValue[31].
REQ-011 SHALL perform one 1-bit step per clock in SHIFT:
- LSL: C=V[31], V=V<<1.
- LSR: C=V[0], V=V>>1.
- ASR: C=V[0], V={V[31],V[31:1]}.
- ROR: C=V[0], V={V[0],V[31:1]}.
- RRX: C=V[0], V={C_old,V[31:1]}.
REQ-012 SHALL hold a 6-bit down-counter loaded with N; the accept edge moves to SHIFT if N>0, else directly to DONE; in SHIFT the edge with counter=1 moves to DONE.
REQ-013 Latency: with the accept edge as edge 0, done SHALL be high exactly in the cycle after edge N; DONE always returns to IDLE on the next edge.
REQ-014 secondValue=V and carryOut=C SHALL be valid while done=1 and held unchanged in IDLE until the next accept.
REQ-015 Intermediate V/C during SHIFT SHALL be visible on the outputs; consumers use them only when done=1.
REQ-016 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle is accepted, giving a minimum issue interval of N+2 cycles.
REQ-017 Results SHALL be bit-exact to ARM shifter-operand semantics, including LSL/LSR by 32 (result 0, C=bit out) and by >32 (result 0, C=0).

Reset
REQ-018 rst=0 SHALL immediately force IDLE, counter=0, busy=0, done=0, secondValue=0, carryOut=0, regardless of clk.
REQ-019 Reset mid-operation SHALL discard the operation; no done pulse follows reset release.
REQ-020 The first start after reset release SHALL be accepted on the first rising edge where rst=1 and start=1.

Verification
REQ-021 Immediate rotate: I=1, shiftOperand=12'h4FF, carryIn=0 -> done after edge 8, secondValue=32'hFF000000, carryOut=1.
REQ-022 LSL immediate: I=0, shiftOperand=12'h200, RmValue=32'h10000001 -> done after edge 4, secondValue=32'h00000010, carryOut=1.
REQ-023 RRX: shiftOperand=12'h060, RmValue=32'h00000003, carryIn=1 -> done after edge 1, secondValue=32'h80000001, carryOut=1.
REQ-024 Register LSR by 40: shiftOperand=12'h030, RsValue=8'd40, RmValue=32'hFFFFFFFF -> done after edge 33, secondValue=0, carryOut=0; a start pulse mid-operation is ignored.
REQ-025 Load/store: loadOrStore=1, shiftOperand=12'hABC, carryIn=1 -> done after edge 0, secondValue=32'h00000ABC, carryOut=1.
REQ-026 Reset mid-SHIFT: rst=0 at edge 5 of a 20-step operation -> busy, done, secondValue and carryOut go to 0 immediately; no done pulse follows release; the next start completes normally.
